path_sched: RTL

Sequencer and two-way arbiter for the shared survivor-path selection engine in the turbo decoder. Accepts branch-metric windows (14 × 30-bit metrics) from the two SISO decoders, grants the engine round-robin, and launches one selection per window. Waits for completion and returns the 4-bit survivor index tagged with its source. Sits between the SISO metric generators and the path-selection engine; the engine is driven only through this block.

---
 rtl/path_sched_pkg.sv | 16 +
 rtl/path_sched_rr.sv | 21 ++
 rtl/path_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/path_sched_pkg.sv
// Shared defaults and types for the path_sched survivor-path sequencer.
package path_sched_pkg;

    localparam int unsigned DEF_BM_W   = 30;
    localparam int unsigned DEF_NUM_BM = 14;
    localparam int unsigned DEF_IDX_W  = 4;
    localparam int unsigned DEF_BM_VEC_W = DEF_NUM_BM * DEF_BM_W;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        HOLD
    } state_t;

endpackage

// File: rtl/path_sched_rr.sv
// Two-way round-robin arbiter: on contention, grants the requester not served last.
module path_sched_rr (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_src,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (enable) begin
            if (valid0 && (!valid1 || last_src)) begin
                grant[0] = 1'b1;
            end else if (valid1) begin
                grant[1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/path_sched.sv
// Sequencer/arbiter for the shared survivor-path selection engine.
// Optional timeout abort in WAIT is enabled by defining PATH_SCHED_TIMEOUT_EN.
module path_sched
    import path_sched_pkg::*;
#(
    parameter int unsigned BM_W    = DEF_BM_W,
    parameter int unsigned NUM_BM  = DEF_NUM_BM,
    parameter int unsigned IDX_W   = DEF_IDX_W,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [NUM_BM*BM_W-1:0]   req0_bm,
    input  logic                     req0_last,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [NUM_BM*BM_W-1:0]   req1_bm,
    input  logic                     req1_last,
    output logic                     ps_start,
    output logic [NUM_BM*BM_W-1:0]   ps_bm,
    input  logic                     ps_done,
    input  logic [IDX_W-1:0]         ps_idx,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [IDX_W-1:0]         res_idx,
    output logic                     res_src,
    output logic                     res_last,
    output logic                     res_err,
    output logic                     busy
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("path_sched: TIMEOUT must be at least 2");
    end

    state_t     state;
    logic       last_src;
    logic       cap_src;
    logic       cap_last;
    logic [1:0] grant;
    logic       accept;
    logic       timed_out;

    // Arbitration is blocked while rst is high so nothing handshakes into a reset.
    path_sched_rr u_rr (
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .last_src (last_src),
        .enable   ((state == IDLE) && !rst),
        .grant    (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = |grant;

`ifdef PATH_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || state == LAUNCH) begin
            wait_cnt <= '0;
        end else if (state == WAIT && wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_src  <= 1'b1;
            cap_src   <= 1'b0;
            cap_last  <= 1'b0;
            ps_start  <= 1'b0;
            ps_bm     <= '0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_src   <= 1'b0;
            res_last  <= 1'b0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ps_bm    <= grant[1] ? req1_bm : req0_bm;
                        cap_last <= grant[1] ? req1_last : req0_last;
                        cap_src  <= grant[1];
                        last_src <= grant[1];
                        ps_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    ps_start <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Exit is either done or timeout; done wins when both coincide.
                    if (ps_done || timed_out) begin
                        res_idx   <= ps_done ? ps_idx : '0;
                        res_err   <= !ps_done;
                        res_src   <= cap_src;
                        res_last  <= cap_last;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
